// File: rtl/ring_wr_cntrl_pkg.sv
// ----------------------------------------------------------------------------
// ring_wr_cntrl_pkg
// Shared definitions for the digitizer ring-buffer write controller:
//   - DEF_SIZE : default ring address width (ring depth 2^DEF_SIZE)
//   - CNT_W    : width of the event statistics counters
//   - state_t  : controller state encoding
//   - is_write_state() : states in which ADC samples are written to the ring
// ----------------------------------------------------------------------------
package ring_wr_cntrl_pkg;

    localparam int DEF_SIZE = 8;
    localparam int CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_POST    = 3'd2,
        ST_READOUT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Samples reach the ring only while pre-trigger (ARMED) or post-trigger
    // (POST) data is being captured; every other state drops them.
    function automatic logic is_write_state(input state_t st);
        logic res;
        case (st)
            ST_ARMED, ST_POST: res = 1'b1;
            default:           res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ring_wr_cntrl_sat_cnt16.sv
// ----------------------------------------------------------------------------
// sat_cnt16
// Increment-enable saturating counter of CNT_W (16) bits. Holds at all-ones
// instead of wrapping, so a statistic never silently restarts from zero.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears the count
//   srst  : synchronous soft reset, clears the count
//   inc   : count one event this cycle
//   cnt   : current count (registered)
// ----------------------------------------------------------------------------
module sat_cnt16
    import ring_wr_cntrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Counter register: clears on either reset, stops at CNT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (srst) begin
            cnt_r <= CNT_ZERO;
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/ring_wr_cntrl.sv
// ----------------------------------------------------------------------------
// ring_wr_cntrl
// Write-side controller of the digitizer ring buffer. The write pointer
// free-runs on every ADC sample while armed; an accepted trigger captures a
// programmable number of post-trigger samples, after which the pointer is
// frozen and rd_request is raised for the readout stage. When the readout
// stage reports completion (ro_done_n low) the controller pulses evt_done and
// re-arms (or parks in IDLE when enable is low).
//
// Parameters:
//   SIZE         : ring address width, ring depth 2^SIZE
//   REQUIRE_FILL : 1 = ignore triggers until the ring holds 2^SIZE samples
//                  written since arming from IDLE
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : run enable, low parks the block in IDLE
//   adc_valid    : one-cycle sample strobe
//   trigger      : trigger request, sampled every cycle
//   posttrig_i   : post-trigger sample count, latched at trigger accept
//   ro_done_n    : readout stage completion, active low
//   wr_addr      : next ring location to write (RAM + readout current address)
//   wr_en        : RAM write enable (adc_valid gated by state)
//   rd_request   : readout in progress, wr_addr frozen while high
//   filled       : 2^SIZE samples written since leaving IDLE
//   evt_done     : one-cycle pulse after each completed readout
//   trig_cnt     : accepted triggers, wraps
//   missed_cnt   : triggers seen while busy with an event, saturates
// ----------------------------------------------------------------------------
module ring_wr_cntrl
    import ring_wr_cntrl_pkg::*;
#(
    parameter int SIZE         = DEF_SIZE,
    parameter int REQUIRE_FILL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             adc_valid,
    input  logic             trigger,
    input  logic [SIZE-1:0]  posttrig_i,
    input  logic             ro_done_n,
    output logic [SIZE-1:0]  wr_addr,
    output logic             wr_en,
    output logic             rd_request,
    output logic             filled,
    output logic             evt_done,
    output logic [CNT_W-1:0] trig_cnt,
    output logic [CNT_W-1:0] missed_cnt
);

    localparam logic [SIZE-1:0]  ADDR_ZERO  = {SIZE{1'b0}};
    localparam logic [SIZE-1:0]  ADDR_ONE   = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE:0]    FILL_ZERO  = {(SIZE+1){1'b0}};
    localparam logic [SIZE:0]    FILL_ONE   = {{SIZE{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TRIG_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TRIG_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             FILL_BYPASS = (REQUIRE_FILL == 0) ? 1'b1 : 1'b0;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [SIZE-1:0]  wr_addr_r;
    logic [SIZE-1:0]  posttrig_r;
    logic [SIZE-1:0]  post_cnt_r;
    // One bit wider than the address so that exactly 2^SIZE writes set the
    // MSB; the counter then stops there, so the MSB is the filled flag.
    logic [SIZE:0]    fill_cnt_r;
    logic [CNT_W-1:0] trig_cnt_r;
    logic             rd_request_r;
    logic             evt_done_r;

    logic             filled_s;
    logic             wr_en_s;
    logic             missed_inc_s;
    logic             arm_from_idle_s;
    logic             accept_s;
    logic             post_last_s;
    logic             ro_exit_s;

    assign filled_s = fill_cnt_r[SIZE];

    // Event decode shared by the next-state logic and the datapath registers.
    always_comb begin
        arm_from_idle_s = 1'b0;
        accept_s        = 1'b0;
        post_last_s     = 1'b0;
        ro_exit_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arm_from_idle_s = enable;
            end
            ST_ARMED: begin
                // Dropping enable takes priority over a trigger in the same cycle.
                accept_s = enable && trigger && (filled_s || FILL_BYPASS);
            end
            ST_POST: begin
                post_last_s = wr_en_s && ((post_cnt_r + ADDR_ONE) == posttrig_r);
            end
            ST_READOUT: begin
                ro_exit_s = rd_request_r && !ro_done_n;
            end
            ST_DONE: begin
                arm_from_idle_s = 1'b0;
            end
            default: begin
                arm_from_idle_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (accept_s) begin
                    // A zero post-trigger count skips POST entirely.
                    if (posttrig_i == ADDR_ZERO) begin
                        state_nxt_s = ST_READOUT;
                    end else begin
                        state_nxt_s = ST_POST;
                    end
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_POST: begin
                // enable is deliberately ignored so a started event completes.
                if (post_last_s) begin
                    state_nxt_s = ST_READOUT;
                end else begin
                    state_nxt_s = ST_POST;
                end
            end
            ST_READOUT: begin
                if (ro_exit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_READOUT;
                end
            end
            ST_DONE: begin
                if (enable) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: RAM write strobe and missed-trigger strobe per state.
    always_comb begin
        wr_en_s      = adc_valid && is_write_state(state_r);
        missed_inc_s = 1'b0;
        case (state_r)
            ST_POST, ST_READOUT, ST_DONE: begin
                missed_inc_s = trigger;
            end
            default: begin
                missed_inc_s = 1'b0;
            end
        endcase
    end

    // Write pointer: advances on every accepted sample, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r <= ADDR_ZERO;
        end else if (wr_en_s) begin
            wr_addr_r <= wr_addr_r + ADDR_ONE;
        end else begin
            wr_addr_r <= wr_addr_r;
        end
    end

    // Fill counter: restarts when arming from IDLE, kept across re-arm from DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_r <= FILL_ZERO;
        end else if (arm_from_idle_s) begin
            fill_cnt_r <= FILL_ZERO;
        end else if (wr_en_s && !filled_s) begin
            fill_cnt_r <= fill_cnt_r + FILL_ONE;
        end else begin
            fill_cnt_r <= fill_cnt_r;
        end
    end

    // Post-trigger length latch and post-trigger write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posttrig_r <= ADDR_ZERO;
            post_cnt_r <= ADDR_ZERO;
        end else if (accept_s) begin
            // The accept-cycle sample is pre-trigger, so counting starts at 0.
            posttrig_r <= posttrig_i;
            post_cnt_r <= ADDR_ZERO;
        end else if ((state_r == ST_POST) && wr_en_s) begin
            posttrig_r <= posttrig_r;
            post_cnt_r <= post_cnt_r + ADDR_ONE;
        end else begin
            posttrig_r <= posttrig_r;
            post_cnt_r <= post_cnt_r;
        end
    end

    // Accepted-trigger counter, wraps at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cnt_r <= TRIG_ZERO;
        end else if (accept_s) begin
            trig_cnt_r <= trig_cnt_r + TRIG_ONE;
        end else begin
            trig_cnt_r <= trig_cnt_r;
        end
    end

    // Registered handshake outputs, aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_request_r <= 1'b0;
            evt_done_r   <= 1'b0;
        end else begin
            rd_request_r <= (state_nxt_s == ST_READOUT);
            evt_done_r   <= (state_nxt_s == ST_DONE);
        end
    end

    sat_cnt16 u_missed_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (1'b0),
        .inc   (missed_inc_s),
        .cnt   (missed_cnt)
    );

    assign wr_addr    = wr_addr_r;
    assign wr_en      = wr_en_s;
    assign rd_request = rd_request_r;
    assign filled     = filled_s;
    assign evt_done   = evt_done_r;
    assign trig_cnt   = trig_cnt_r;

endmodule

// File: tb/tb_ring_wr_cntrl.sv
// ----------------------------------------------------------------------------
// tb_ring_wr_cntrl
// Scoreboard bench for ring_wr_cntrl (SIZE=8, REQUIRE_FILL=1). The stimulus
// process drives one cycle at a time and advances a behavioural model of the
// write controller; the model pushes the expected per-cycle status, expected
// write addresses and expected end-of-event records into queues. A monitor on
// the falling clock edge pops and compares whenever the DUT shows a cycle,
// a RAM write or an evt_done pulse.
// ----------------------------------------------------------------------------
module tb_ring_wr_cntrl;

    localparam int SIZE  = 8;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic wr;
        logic rdq;
        logic fil;
        logic evd;
    } st_t;

    typedef struct packed {
        logic [15:0] trig;
        logic [15:0] missed;
        logic [7:0]  addr;
    } ev_t;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            adc_valid;
    logic            trigger;
    logic [SIZE-1:0] posttrig_i;
    logic            ro_done_n;
    logic [SIZE-1:0] wr_addr;
    logic            wr_en;
    logic            rd_request;
    logic            filled;
    logic            evt_done;
    logic [15:0]     trig_cnt;
    logic [15:0]     missed_cnt;

    int n_vec;
    int n_bad;

    st_t  sq[$];
    int   wq[$];
    ev_t  eq[$];

    // Reference model state.
    string m_mode;
    int    m_addr;
    int    m_written;
    int    m_left;
    int    m_trig;
    int    m_missed;

    ring_wr_cntrl #(
        .SIZE         (SIZE),
        .REQUIRE_FILL (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .adc_valid  (adc_valid),
        .trigger    (trigger),
        .posttrig_i (posttrig_i),
        .ro_done_n  (ro_done_n),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .rd_request (rd_request),
        .filled     (filled),
        .evt_done   (evt_done),
        .trig_cnt   (trig_cnt),
        .missed_cnt (missed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = "IDLE";
        m_addr    = 0;
        m_written = 0;
        m_left    = 0;
        m_trig    = 0;
        m_missed  = 0;
    endtask

    // One clock cycle: apply inputs, record expectations, advance the model.
    task automatic cycle(input bit en, input bit av, input bit tr, input int pt, input bit rd);
        bit    wr;
        bit    full;
        bit    busy;
        st_t   st;
        ev_t   ev;
        string cur;
        logic [31:0] ptv;
        ptv        = pt;
        enable     = en;
        adc_valid  = av;
        trigger    = tr;
        posttrig_i = ptv[SIZE-1:0];
        ro_done_n  = rd;
        cur  = m_mode;
        full = (m_written >= DEPTH);
        wr   = av && (cur == "ARMED" || cur == "POST");
        busy = (cur == "POST" || cur == "READOUT" || cur == "DONE");
        st.wr  = wr;
        st.rdq = (cur == "READOUT");
        st.fil = full;
        st.evd = (cur == "DONE");
        sq.push_back(st);
        if (wr) wq.push_back(m_addr);
        if (cur == "DONE") begin
            ev.trig   = m_trig[15:0];
            ev.missed = m_missed[15:0];
            ev.addr   = m_addr[7:0];
            eq.push_back(ev);
        end
        // Consequences of this cycle, taking effect at the clock edge.
        if (tr && busy && m_missed < 65535) m_missed++;
        if (wr) begin
            m_addr = (m_addr + 1) % DEPTH;
            if (m_written < DEPTH) m_written++;
        end
        if (cur == "IDLE") begin
            if (en) begin
                m_mode    = "ARMED";
                m_written = 0;
            end
        end else if (cur == "ARMED") begin
            if (!en) m_mode = "IDLE";
            else if (tr && full) begin
                m_trig = (m_trig + 1) % 65536;
                m_left = pt;
                m_mode = (pt == 0) ? "READOUT" : "POST";
            end
        end else if (cur == "POST") begin
            if (av) begin
                m_left--;
                if (m_left == 0) m_mode = "READOUT";
            end
        end else if (cur == "READOUT") begin
            if (!rd) m_mode = "DONE";
        end else begin
            m_mode = en ? "ARMED" : "IDLE";
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit en, input bit av, input bit tr, input int pt, input bit rd);
        for (int i = 0; i < n; i++) cycle(en, av, tr, pt, rd);
    endtask

    // Monitor: compares whatever the DUT presents in the middle of each cycle.
    always @(negedge clk) begin : mon
        st_t st;
        ev_t ev;
        if (sq.size() > 0) begin
            st = sq.pop_front();
            chk("wr_en", {31'd0, wr_en}, {31'd0, st.wr});
            chk("rd_request", {31'd0, rd_request}, {31'd0, st.rdq});
            chk("filled", {31'd0, filled}, {31'd0, st.fil});
            chk("evt_done", {31'd0, evt_done}, {31'd0, st.evd});
        end
        if (wr_en) begin
            if (wq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got wr_en=1 addr %0h expected no write", wr_addr);
            end else begin
                chk("wr_addr", {24'd0, wr_addr}, wq.pop_front());
            end
        end
        if (evt_done) begin
            if (eq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_evt_done: got evt_done=1 expected 0");
            end else begin
                ev = eq.pop_front();
                chk("evt_trig_cnt", {16'd0, trig_cnt}, {16'd0, ev.trig});
                chk("evt_missed_cnt", {16'd0, missed_cnt}, {16'd0, ev.missed});
                chk("evt_wr_addr", {24'd0, wr_addr}, {24'd0, ev.addr});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pt;
        n_vec = 0;
        n_bad = 0;
        model_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        adc_valid  = 1'b0;
        trigger    = 1'b0;
        posttrig_i = 8'd0;
        ro_done_n  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_rd_request", {31'd0, rd_request}, 32'd0);
        chk("rst_filled", {31'd0, filled}, 32'd0);
        chk("rst_evt_done", {31'd0, evt_done}, 32'd0);
        chk("rst_trig_cnt", {16'd0, trig_cnt}, 32'd0);
        chk("rst_missed_cnt", {16'd0, missed_cnt}, 32'd0);
        rst_n = 1'b1;

        // Fill gating: trigger held high, no accept before 256 writes.
        run(1, 1, 1, 1, 0, 1);
        run(256, 1, 1, 1, 0, 1);
        chk("fill_filled", {31'd0, filled}, 32'd1);
        chk("fill_trig_blocked", {16'd0, trig_cnt}, 32'd0);
        chk("fill_wrap_addr", {24'd0, wr_addr}, 32'd0);
        run(1, 1, 1, 1, 0, 1);
        chk("fill_accept", {16'd0, trig_cnt}, 32'd1);
        chk("fill_rdreq", {31'd0, rd_request}, 32'd1);
        // ro_done_n already low: exactly one READOUT cycle.
        run(1, 1, 0, 0, 0, 0);
        chk("fast_done_evt", {31'd0, evt_done}, 32'd1);
        run(1, 1, 0, 0, 0, 1);
        chk("rearm_filled_kept", {31'd0, filled}, 32'd1);

        // Post-trigger count: accept at 0x10, 5 more writes.
        run(15, 1, 1, 0, 0, 1);
        chk("pre_addr", {24'd0, wr_addr}, 32'h10);
        run(1, 1, 1, 1, 5, 1);
        for (int k = 0; k < 9; k++) cycle(1'b1, (k % 2) == 0, 1'b0, 0, 1'b1);
        chk("post_frozen_addr", {24'd0, wr_addr}, 32'h16);
        chk("post_rdreq", {31'd0, rd_request}, 32'd1);

        // Handshake held off 20 cycles, with dropped samples and 3 missed triggers.
        run(17, 1, 1, 0, 0, 1);
        run(3, 1, 1, 1, 0, 1);
        chk("hold_rdreq", {31'd0, rd_request}, 32'd1);
        chk("hold_addr", {24'd0, wr_addr}, 32'h16);
        chk("hold_missed", {16'd0, missed_cnt}, 32'd3);
        chk("hold_trig", {16'd0, trig_cnt}, 32'd2);
        run(1, 1, 0, 0, 0, 0);
        chk("done_rdreq_low", {31'd0, rd_request}, 32'd0);
        run(1, 1, 1, 0, 0, 1);
        chk("done_pulse_once", {31'd0, evt_done}, 32'd0);
        run(1, 1, 1, 0, 0, 1);
        chk("resume_addr", {24'd0, wr_addr}, 32'h17);

        // Wrap with zero post-trigger count.
        run(232, 1, 1, 0, 0, 1);
        chk("wrap_pre", {24'd0, wr_addr}, 32'hFF);
        run(1, 1, 1, 1, 0, 1);
        chk("wrap_addr", {24'd0, wr_addr}, 32'h00);
        run(3, 1, 1, 1, 0, 1);
        chk("wrap_missed", {16'd0, missed_cnt}, 32'd6);
        chk("wrap_trig", {16'd0, trig_cnt}, 32'd3);

        // Asynchronous reset in READOUT at wr_addr 0x37.
        run(1, 1, 0, 0, 0, 0);
        run(1, 1, 0, 0, 0, 1);
        run(55, 1, 1, 0, 0, 1);
        run(1, 1, 0, 1, 0, 1);
        chk("pre_rst_addr", {24'd0, wr_addr}, 32'h37);
        chk("pre_rst_rdreq", {31'd0, rd_request}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rdreq", {31'd0, rd_request}, 32'd0);
        chk("async_addr", {24'd0, wr_addr}, 32'd0);
        chk("async_trig", {16'd0, trig_cnt}, 32'd0);
        chk("async_missed", {16'd0, missed_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run(1, 0, 1, 1, 0, 1);

        // Enable dropped in POST: event completes, then DONE -> IDLE.
        run(1, 1, 0, 0, 0, 1);
        run(256, 1, 1, 0, 0, 1);
        run(1, 1, 1, 1, 4, 1);
        run(4, 0, 1, 0, 0, 1);
        chk("noen_rdreq", {31'd0, rd_request}, 32'd1);
        run(1, 0, 0, 0, 0, 0);
        chk("noen_evt", {31'd0, evt_done}, 32'd1);
        run(1, 0, 0, 0, 0, 1);
        run(2, 0, 1, 1, 0, 1);

        // missed_cnt saturation.
        run(1, 1, 0, 0, 0, 1);
        run(256, 1, 1, 0, 0, 1);
        run(1, 1, 0, 1, 0, 1);
        run(65537, 1, 0, 1, 0, 1);
        chk("sat_missed", {16'd0, missed_cnt}, 32'hFFFF);
        run(1, 1, 0, 0, 0, 0);
        run(1, 1, 0, 0, 0, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 8000; i++) begin
            case ($urandom_range(0, 9))
                0:       pt = 0;
                1:       pt = 255;
                default: pt = $urandom_range(1, 12);
            endcase
            cycle($urandom_range(0, 999) < 997,
                  $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 10,
                  pt,
                  $urandom_range(0, 99) >= 25);
        end

        run(1, 0, 0, 0, 0, 1);
        chk("end_trig_cnt", {16'd0, trig_cnt}, m_trig);
        chk("end_missed_cnt", {16'd0, missed_cnt}, m_missed);
        chk("end_write_queue", wq.size(), 32'd0);
        chk("end_event_queue", eq.size(), 32'd0);
        chk("end_status_queue", sq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
